// File: rtl/imem_rr_arbiter_pkg.sv
// Shared constants and types for the instruction-ROM round-robin arbiter.
// Core count, ROM index width and word width are set here for the whole MCU.
package imem_rr_arbiter_pkg;
   localparam int N_CORES = 8;
   localparam int IMEM_WA = 7;
   localparam int XLEN    = 32;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/imem_rr_arbiter_if.sv
// Core-fetch and ROM-side signals of the shared instruction ROM arbiter.
interface imem_rr_arbiter_if #(
   parameter int N_REQ = 8,
   parameter int AW    = 32,
   parameter int WA    = 7,
   parameter int DW    = 32
);
   logic [N_REQ-1:0]    req_i;
   logic [N_REQ*AW-1:0] addr_i;
   logic [N_REQ-1:0]    gnt_o;
   logic [N_REQ-1:0]    rvalid_o;
   logic [DW-1:0]       rdata_o;
   logic                rom_en_o;
   logic [WA-1:0]       rom_addr_o;
   logic [DW-1:0]       rom_dout_i;

   modport slave (
      input  req_i, addr_i, rom_dout_i,
      output gnt_o, rvalid_o, rdata_o, rom_en_o, rom_addr_o
   );

   modport master (
      output req_i, addr_i, rom_dout_i,
      input  gnt_o, rvalid_o, rdata_o, rom_en_o, rom_addr_o
   );
endinterface

// File: rtl/imem_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr,
// wrapping modulo N, returned as one-hot gnt plus its binary index.
module imem_rr_arbiter_rr_pick
   import imem_rr_arbiter_pkg::*;
#(
   parameter int N  = 8,
   parameter int PW = ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx
);
   always_comb begin
      int  c;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int off = 0; off < N; off++) begin
         c = int'(ptr) + off;
         if (c >= N) c = c - N;
         if (!found && req[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            idx    = PW'(c);
         end
      end
   end
endmodule

// File: rtl/imem_rr_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency instruction ROM among
// N_REQ fetch units; holds the priority pointer and the rvalid register.
module imem_rr_arbiter
   import imem_rr_arbiter_pkg::*;
#(
   parameter int N_REQ = N_CORES,
   parameter int AW    = XLEN,
   parameter int WA    = IMEM_WA,
   parameter int DW    = XLEN
) (
   input  logic              clka,
   input  logic              reset,
   imem_rr_arbiter_if.slave  bus
);
   localparam int PW = ptr_w(N_REQ);

   logic [N_REQ-1:0][AW-1:0] addr_w;
   logic [N_REQ-1:0]         pick_gnt;
   logic [PW-1:0]            pick_idx;
   logic [PW-1:0]            rr_ptr;
   logic [N_REQ-1:0]         rvalid_q;
   logic [N_REQ-1:0]         gnt;

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      assign addr_w[i] = bus.addr_i[i*AW +: AW];
   end

   imem_rr_arbiter_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
      .req (bus.req_i),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // Nothing reaches the ROM while reset is held, whatever the cores request.
   assign gnt            = reset ? '0 : pick_gnt;
   assign bus.gnt_o      = gnt;
   assign bus.rom_en_o   = |gnt;
   // Byte offset dropped; bits above the ROM depth wrap.
   assign bus.rom_addr_o = addr_w[pick_idx][WA+1:2];
   assign bus.rdata_o    = bus.rom_dout_i;
   // A response registered just before reset is not presented during reset.
   assign bus.rvalid_o   = reset ? '0 : rvalid_q;

   always_ff @(posedge clka) begin
      if (reset) begin
         rr_ptr   <= '0;
         rvalid_q <= '0;
      end else begin
         rvalid_q <= gnt;
         if (|gnt)
            rr_ptr <= (int'(pick_idx) == N_REQ-1) ? '0 : pick_idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_imem_rr_arbiter.sv
// Directed bench for imem_rr_arbiter with a behavioural ROM and a queue of
// expected responses pushed per grant and popped one cycle later.
module tb_imem_rr_arbiter;
   localparam int N  = 8;
   localparam int AW = 32;
   localparam int WA = 7;
   localparam int DW = 32;

   typedef struct {
      logic [N-1:0]  v;
      logic [DW-1:0] d;
   } resp_t;

   logic clka = 1'b0;
   logic reset;
   always #5 clka = ~clka;

   imem_rr_arbiter_if #(.N_REQ(N), .AW(AW), .WA(WA), .DW(DW)) bus ();

   imem_rr_arbiter #(.N_REQ(N), .AW(AW), .WA(WA), .DW(DW)) dut (
      .clka  (clka),
      .reset (reset),
      .bus   (bus.slave)
   );

   logic [DW-1:0] rom [0:(1<<WA)-1];
   logic [DW-1:0] rom_q;
   always @(posedge clka) if (bus.rom_en_o) rom_q <= rom[bus.rom_addr_o];
   assign bus.rom_dout_i = rom_q;

   logic [AW-1:0] addrs [0:N-1];
   resp_t q [$];
   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [N-1:0] req);
      logic [N-1:0] eg;
      int k;
      int ea;
      resp_t r;
      reset      = rst;
      bus.req_i  = req;
      for (int i = 0; i < N; i++) bus.addr_i[i*AW +: AW] = addrs[i];
      @(negedge clka);
      eg = '0;
      k  = -1;
      if (!rst)
         for (int off = 0; off < N; off++)
            if (k < 0 && req[(m_ptr + off) % N]) k = (m_ptr + off) % N;
      if (k >= 0) eg[k] = 1'b1;
      chk("gnt", 64'(bus.gnt_o), 64'(eg));
      chk("rom_en", 64'(bus.rom_en_o), 64'(k >= 0));
      ea = 0;
      if (k >= 0) begin
         ea = int'((addrs[k] >> 2) % (1 << WA));
         chk("rom_addr", 64'(bus.rom_addr_o), 64'(ea));
      end
      if (q.size() > 0) begin
         r = q.pop_front();
         if (rst) r.v = '0;
         chk("rvalid", 64'(bus.rvalid_o), 64'(r.v));
         if (r.v != 0) chk("rdata", 64'(bus.rdata_o), 64'(r.d));
      end
      r.v = eg;
      r.d = rom[ea];
      q.push_back(r);
      if (rst) m_ptr = 0;
      else if (k >= 0) m_ptr = (k + 1) % N;
      @(posedge clka);
      #1;
   endtask

   initial begin
      for (int i = 0; i < (1 << WA); i++) rom[i] = 32'hA5C3_0000 ^ (i * 32'h0101_0107);
      for (int i = 0; i < N; i++) addrs[i] = 32'(i * 4);
      // reset with every core requesting
      repeat (3) step(1'b1, 8'hFF);
      // all cores requesting: rotating grant, varied addresses
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < N; i++) addrs[i] = $urandom;
         step(1'b0, 8'hFF);
      end
      // single requester streaming sequential words
      addrs[3] = 32'h0C; step(1'b0, 8'h08);
      addrs[3] = 32'h10; step(1'b0, 8'h08);
      addrs[3] = 32'h14; step(1'b0, 8'h08);
      // misaligned address above ROM depth
      addrs[5] = 32'h0000_0207; step(1'b0, 8'h20);
      // move pointer to 7, then contend cores 7 and 0, then show ptr=1
      addrs[6] = 32'h40; step(1'b0, 8'h40);
      addrs[7] = 32'h44; addrs[0] = 32'h48;
      step(1'b0, 8'h81);
      step(1'b0, 8'h81);
      addrs[1] = 32'h4C; step(1'b0, 8'h03);
      // request dropped with no grant pending, then idle
      step(1'b0, 8'h00);
      // reset the cycle after a grant
      addrs[0] = 32'h50; step(1'b0, 8'h01);
      step(1'b1, 8'h01);
      step(1'b1, 8'h00);
      addrs[1] = 32'h54; addrs[2] = 32'h58;
      step(1'b0, 8'h06);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
